// File: rtl/neq_tally_if.sv
// dti valid/ready stream interface carrying a W-bit data word.
interface dti #(
    parameter int W = 1
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master   (output valid, output data, input ready);
    modport slave    (input valid, input data, output ready);
    // producer/consumer are the stream-role names neighbouring blocks connect with
    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/neq_tally.sv
// Counts 1-flags per eot-delimited transaction of a dti flag stream, one registered result per transaction.
// Optional NEQ_TALLY_TOTAL_EN adds a per-transaction element count: dout.data = {tot_out, ones_out}.
module neq_tally #(
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    dti.consumer din,
    dti.producer dout
);
    typedef enum logic {
        IDLE_EMPTY = 1'b0,
        HOLD       = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic             out_valid;
    logic             hs_in;
    logic             hs_out;
    logic             flag;
    logic             eot;
    logic             close;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_inc;
    logic [CNT_W-1:0] ones_out;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic f);
        return (f && (a != CNT_MAX)) ? a + CNT_W'(1) : a;
    endfunction

    assign flag      = din.data[0];
    assign eot       = din.data[1];
    assign out_valid = (state == HOLD);
    // Stall input whenever the result register is full and not draining this cycle
    assign din.ready = ~out_valid | dout.ready;
    assign hs_in     = din.valid & din.ready;
    assign hs_out    = out_valid & dout.ready;
    assign close     = hs_in & eot;
    assign acc_inc   = sat_add(acc, flag);

    always_comb begin
        state_next = state;
        case (state)
            IDLE_EMPTY: if (close) state_next = HOLD;
            HOLD:       if (hs_out && !close) state_next = IDLE_EMPTY;
            default:    state_next = IDLE_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE_EMPTY;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc      <= '0;
            ones_out <= '0;
        end else if (hs_in) begin
            if (eot) begin
                ones_out <= acc_inc;
                acc      <= '0;
            end else begin
                acc <= acc_inc;
            end
        end
    end

`ifdef NEQ_TALLY_TOTAL_EN
    logic [CNT_W-1:0] tot;
    logic [CNT_W-1:0] tot_inc;
    logic [CNT_W-1:0] tot_out;

    assign tot_inc = sat_add(tot, 1'b1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tot     <= '0;
            tot_out <= '0;
        end else if (hs_in) begin
            if (eot) begin
                tot_out <= tot_inc;
                tot     <= '0;
            end else begin
                tot <= tot_inc;
            end
        end
    end

    assign dout.data = {tot_out, ones_out};
`else
    assign dout.data = ones_out;
`endif

    assign dout.valid = out_valid;
endmodule

// File: tb/tb_neq_tally.sv
// Self-checking bench for neq_tally: directed scenarios plus randomized frames against a frame-count model.
module tb_neq_tally;
    localparam int CNT_W = 4;
`ifdef NEQ_TALLY_TOTAL_EN
    localparam int OUT_W = 2 * CNT_W;
`else
    localparam int OUT_W = CNT_W;
`endif
    localparam int MAXV = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dti #(.W(2))     din_if ();
    dti #(.W(OUT_W)) dout_if ();

    neq_tally #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din_if),
        .dout (dout_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: ones/elements seen in the open frame, results not yet drained
    int               cur_ones;
    int               cur_n;
    logic [OUT_W-1:0] exp_q[$];

    // 0: ready low, 1: ready high, 2: random
    int ready_mode;

    function automatic logic [OUT_W-1:0] frame_result(input int ones, input int n);
        int o;
        int t;
        o = (ones > MAXV) ? MAXV : ones;
        t = (n > MAXV) ? MAXV : n;
`ifdef NEQ_TALLY_TOTAL_EN
        return {t[CNT_W-1:0], o[CNT_W-1:0]};
`else
        return o[CNT_W-1:0];
`endif
    endfunction

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("out_valid", OUT_W'(dout_if.valid), OUT_W'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("out_data", dout_if.data, exp_q[0]);
    endtask

    // One clock cycle: drive on negedge, observe handshakes, update model after posedge
    task automatic apply_stimulus(input logic v, input logic f, input logic e, output logic accepted);
        logic hs_in;
        logic hs_out;
        @(negedge clk);
        din_if.valid = v;
        din_if.data  = {e, f};
        case (ready_mode)
            0:       dout_if.ready = 1'b0;
            1:       dout_if.ready = 1'b1;
            default: dout_if.ready = ($urandom_range(0, 1) == 1);
        endcase
        #1;
        if (rst) check("in_ready", OUT_W'(din_if.ready), OUT_W'(!dout_if.valid || dout_if.ready));
        hs_in  = v & din_if.ready;
        hs_out = dout_if.valid & dout_if.ready;
        @(posedge clk);
        #1;
        accepted = 1'b0;
        if (!rst) begin
            cur_ones = 0;
            cur_n    = 0;
            exp_q.delete();
        end else begin
            if (hs_out && exp_q.size() != 0) void'(exp_q.pop_front());
            if (hs_in) begin
                accepted = 1'b1;
                cur_n++;
                cur_ones += int'(f);
                if (e) begin
                    exp_q.push_back(frame_result(cur_ones, cur_n));
                    cur_ones = 0;
                    cur_n    = 0;
                end
            end
        end
        check_output();
    endtask

    task automatic send(input logic f, input logic e);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) apply_stimulus(1'b1, f, e, ok);
        check("send_accept", OUT_W'(ok), OUT_W'(1));
    endtask

    task automatic idle(input int n);
        logic dummy;
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, dummy);
    endtask

    initial begin
        logic acc_flag;
        int   len;
        din_if.valid  = 1'b0;
        din_if.data   = '0;
        dout_if.ready = 1'b1;
        ready_mode    = 1;
        cur_ones      = 0;
        cur_n         = 0;

        // Reset held with valid input: nothing may be counted
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, acc_flag);
            check("rst_valid", OUT_W'(dout_if.valid), '0);
            check("rst_data", dout_if.data, '0);
        end
        rst = 1'b1;
        idle(2);
        check("rst_noleak", OUT_W'(dout_if.valid), '0);

        // Basic frame 1,0,1,1(eot), then hold result with ready low
        $display("[TB] basic frame and back-pressure");
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        ready_mode = 0;
        send(1'b1, 1'b1);
        check("basic_data", dout_if.data, frame_result(3, 4));
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, acc_flag);
            check("stall_accept", OUT_W'(acc_flag), '0);
            check("stall_data", dout_if.data, frame_result(3, 4));
        end
        ready_mode = 1;
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        check("bp_data", dout_if.data, frame_result(2, 2));

        // Back-to-back single-element frames
        $display("[TB] back-to-back single-element frames");
        send(1'b1, 1'b1);
        check("b2b_0", dout_if.data, frame_result(1, 1));
        send(1'b0, 1'b1);
        check("b2b_1", dout_if.data, frame_result(0, 1));
        send(1'b1, 1'b1);
        check("b2b_2", dout_if.data, frame_result(1, 1));

        // Saturation: 20 ones then eot
        $display("[TB] saturation");
        for (int i = 0; i < 20; i++) send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        check("sat_data", dout_if.data, frame_result(MAXV, MAXV));

        // Reset mid-frame discards partial count
        $display("[TB] reset mid-frame");
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        send(1'b1, 1'b1);
        check("midrst_data", dout_if.data, frame_result(1, 1));

        // Randomized frames with random gaps and random back-pressure
        $display("[TB] random frames");
        ready_mode = 2;
        for (int fr = 0; fr < 40; fr++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 22) : $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send($urandom_range(0, 2) != 0, k == len - 1);
            end
        end
        ready_mode = 1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
